// File: rtl/cd_ext_master.sv
// Initiator for the 16-bit CD extension bus: frames GET_CMD, GET_READY and SET
// transactions as strobed word sequences and captures the responder's replies.
module cd_ext_master #(
  parameter int GAP = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        data_type,
  input  logic [47:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [47:0] rx_data,
  output logic [7:0]  req_count,
  output logic        cmd_new,
  output logic        ready,
  output logic [15:0] bus_dout,
  output logic        bus_strobe,
  output logic        bus_enable,
  input  logic [15:0] bus_din,
  input  logic        bus_din_en
);

  // state    | meaning
  // S_IDLE   | waiting for start, busy low
  // S_SETUP  | frame opened, bus_enable high
  // S_STROBE | word k driven with bus_strobe
  // S_SAMPLE | responder reply for word k captured
  // S_GAP    | frame closed, idle cycles before busy drops
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_SAMPLE, S_GAP} state_t;

  localparam int         GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [1:0] OP_CMD = 2'd0;
  localparam logic [1:0] OP_SET = 2'd2;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          dtype_q, dtype_d;
  logic [47:0]   tx_q, tx_d;
  logic [2:0]    k_q, k_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          claim_q, claim_d;
  logic [7:0]    tmp_q, tmp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [47:0]   rx_q, rx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          cnew_q, cnew_d;
  logic          ready_q, ready_d;
  logic [15:0]   dout_q, dout_d;
  logic          strobe_q, strobe_d;
  logic          enable_q, enable_d;

  logic          is_cmd, is_set;
  logic [2:0]    last_k;

  function automatic logic [15:0] word_at(input logic [2:0] idx, input logic [1:0] o,
                                          input logic dt, input logic [47:0] tx);
    logic [15:0] w;
    w = 16'h0000;
    if (o == OP_SET) begin
      case (idx)
        3'd0:    w = 16'h0035;
        3'd1:    w = tx[15:0];
        3'd2:    w = tx[31:16];
        3'd3:    w = tx[47:32];
        default: w = 16'h0000;
      endcase
    end else if (idx == 3'd0) begin
      w = 16'h0034;
    end else if (idx == 3'd1 && o != OP_CMD) begin
      w = {13'd0, dt, 2'b01};
    end
    return w;
  endfunction

  always_comb begin
    is_cmd   = (op_q == OP_CMD);
    is_set   = (op_q == OP_SET);
    last_k   = is_cmd ? 3'd4 : (is_set ? 3'd3 : 3'd2);

    state_d  = state_q;
    op_d     = op_q;
    dtype_d  = dtype_q;
    tx_d     = tx_q;
    k_d      = k_q;
    gap_d    = gap_q;
    claim_d  = claim_q;
    tmp_d    = tmp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    cnew_d   = cnew_q;
    ready_d  = ready_q;
    dout_d   = 16'h0000;
    strobe_d = 1'b0;
    enable_d = enable_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETUP;
          op_d     = op;
          dtype_d  = data_type;
          tx_d     = tx_data;
          k_d      = 3'd0;
          busy_d   = 1'b1;
          enable_d = 1'b1;
          err_d    = 1'b0;
        end
      end
      S_SETUP: begin
        state_d  = S_STROBE;
        k_d      = 3'd0;
        strobe_d = 1'b1;
        dout_d   = word_at(3'd0, op_q, dtype_q, tx_q);
      end
      S_STROBE: begin
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (k_q == 3'd0) begin
          claim_d = bus_din_en;
          if (!is_set) tmp_d = bus_din[7:0];
        end
        // payload captures rely on the claim flag taken at k=0
        if (is_cmd && claim_q) begin
          case (k_q)
            3'd2:    rx_d[15:0]  = bus_din;
            3'd3:    rx_d[31:16] = bus_din;
            3'd4:    rx_d[47:32] = bus_din;
            default: ;
          endcase
        end
        if (!is_cmd && !is_set && claim_q && k_q == 3'd2) ready_d = bus_din[0];

        if (k_q == last_k) begin
          state_d  = S_GAP;
          enable_d = 1'b0;
          done_d   = 1'b1;
          err_d    = ~claim_q;
          gap_d    = GW'(GAP - 1);
          if (is_cmd && claim_q) begin
            cnt_d  = tmp_q;
            cnew_d = (tmp_q != cnt_q);
          end
        end else begin
          state_d  = S_STROBE;
          k_d      = k_q + 3'd1;
          strobe_d = 1'b1;
          dout_d   = word_at(k_q + 3'd1, op_q, dtype_q, tx_q);
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      dtype_q  <= 1'b0;
      tx_q     <= 48'd0;
      k_q      <= 3'd0;
      gap_q    <= '0;
      claim_q  <= 1'b0;
      tmp_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_q     <= 48'd0;
      cnt_q    <= 8'd0;
      cnew_q   <= 1'b0;
      ready_q  <= 1'b0;
      dout_q   <= 16'h0000;
      strobe_q <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dtype_q  <= dtype_d;
      tx_q     <= tx_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      claim_q  <= claim_d;
      tmp_q    <= tmp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      cnew_q   <= cnew_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      enable_q <= enable_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rx_data    = rx_q;
  assign req_count  = cnt_q;
  assign cmd_new    = cnew_q;
  assign ready      = ready_q;
  assign bus_dout   = dout_q;
  assign bus_strobe = strobe_q;
  assign bus_enable = enable_q;

endmodule

// File: doc/cd_ext_master.md
# cd_ext_master

Initiator side of the 16-bit CD extension bus. It generates the command, strobe and enable sequencing that the FPGA-side CD responder decodes, so the core can exchange CD command/status words with a local controller instead of the HPS. It sits between a simple start/done request port, driven by the CD drive emulation, and the bus pins. It implements three transaction types: CD_GET command read, CD_GET ready query, and CD_SET write.

## Interface
- GAP, 2: idle cycles, minimum 1, with enable low after each transaction before busy drops.
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only when busy=0.
- op  in  2  0=GET_CMD, 1=GET_READY, 2=SET, 3=reserved (treated as GET_READY).
- data_type  in  1  GET_READY selector: 0=CDDA ready, 1=CD data ready.
- tx_data  in  48  SET payload, latched on accept.
- busy  out  1  transaction or gap in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  responder did not claim the command; valid with done.
- rx_data  out  48  GET_CMD result.
- req_count  out  8  responder request counter from the last GET_CMD.
- cmd_new  out  1  last GET_CMD saw a changed req_count.
- ready  out  1  last GET_READY result.
- bus_dout  out  16  word to responder.
- bus_strobe  out  1  one-cycle word strobe.
- bus_enable  out  1  transaction frame.
- bus_din  in  16  word from responder.
- bus_din_en  in  1  responder claims the command.

## Operation
- States: IDLE, SETUP, STROBE, SAMPLE, GAP.
- IDLE: on start, latch op, data_type and tx_data, then go to SETUP.
- SETUP: raise bus_enable, set word index k=0, then go to STROBE.
- STROBE: bus_strobe=1 and bus_dout=word[k], then go to SAMPLE.
- SAMPLE: bus_strobe=0. Capture bus_din and bus_din_en as appropriate. Increment k. Return to STROBE if k<N, otherwise go to GAP.
- GAP: bus_enable=0 and bus_dout=0. done pulses in the first GAP cycle. After GAP cycles, go to IDLE and clear busy.
- Word lists:
  - GET_CMD (N=5): 0x0034, 0x0000, then three 0x0000 reads.
  - GET_READY (N=3): 0x0034, {13'd0, data_type, 2'b01}, then 0x0000.
  - SET (N=4): 0x0035, tx_data[15:0], tx_data[31:16], tx_data[47:32].
- Captures, made in SAMPLE:
  - k=0: bus_din_en into an error flag. For GET ops only, also bus_din[7:0] into a temporary count.
  - GET_CMD k=2,3,4: bus_din into rx_data[15:0], [31:16], [47:32].
  - GET_READY k=2: bus_din[0] into ready.
- On GET_CMD completion with no error, req_count is updated from the temporary count. cmd_new = (new count != previous req_count).
- If the error flag is low (responder did not claim), the transaction still runs its full length. err=1 with done, and rx_data, ready and req_count are left unchanged.
- busy = (state != IDLE).
- start while busy is ignored. start in the same cycle that busy falls is also ignored.
- req_count wraps modulo 256. cmd_new compares for inequality only.

## Timing
- Accept cycle is t0.
- SETUP at t1: bus_enable=1.
- Word k strobe at t2+2k. Its response is sampled at t3+2k, because the responder registers its output on the strobe edge.
- Enable low and done at t2+2N:
  - GET_CMD: t12.
  - GET_READY: t8.
  - SET: t10.
- busy is high from t1 through t(1+2N+GAP). The next start is accepted at the earliest when busy=0.
- bus_dout holds its value only during the STROBE cycle and is 0 otherwise.
- Reset values: all outputs 0, state IDLE. req_count=0, rx_data=0, cmd_new=0, ready=0.
- Reset asserted mid-transaction clears bus_enable and bus_strobe asynchronously. No done pulse is produced.

## Test plan
- GET_CMD with a responder model returning count 0x05 and cd_in 0x1234_5678_9ABC:
  - rx_data=0x123456789ABC, req_count=0x05, cmd_new=1, done at t12, err=0.
  - Repeating with the same count gives cmd_new=0.
- GET_READY with data_type=1, cd_data_ready=1, cdda_ready=0: word1=0x0005, ready=1, done at t8. With data_type=0: ready=0.
- SET with tx_data=0xAAAA_5555_0F0F: the responder receives words 0x0035, 0x0F0F, 0x5555, 0xAAAA in order, and enable drops at t10.
- Responder with bus_din_en forced 0 on GET_CMD: err=1 with done, rx_data unchanged, and exactly 5 strobes issued.
- start pulsed while busy, and again in the cycle busy falls: both ignored; a start one cycle later is accepted. Count wrap 0xFF to 0x00 gives cmd_new=1.
- reset_n dropped at t5 of a SET: bus_enable=0 and bus_strobe=0 immediately, no done. After release, a new GET_CMD completes normally.
